gam_recall_engine: RTL and testbench

- Read-side counterpart of the memory-layer learning datapath. The learning path writes node weight vectors and class labels into node memory; this block reads them back.
- Accepts a query vector and scans every stored node through a single-cycle-latency read port.
- Accumulates squared Euclidean distance element-serially and tracks the running minimum.
- Returns the winning node index, its class and its distance over a valid/ready handshake.

---
 rtl/gam_recall_engine.sv | 159 +++++++++++++++
 tb/tb_gam_recall_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gam_recall_engine.sv
// Nearest-node recall: scans stored node vectors, returns index/class/distance of the closest.
// Optional GAM_RECALL_EARLY_EXIT_EN abandons a node once its partial distance reaches the running min.
module gam_recall_engine #(
  parameter int unsigned DIM      = 4,
  parameter int unsigned ELEM_W   = 16,
  parameter int unsigned NODE_MAX = 64,
  parameter int unsigned NODE_W   = 7,
  parameter int unsigned CLASS_W  = 8,
  parameter int unsigned DIST_W   = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    q_valid,
  output logic                    q_ready,
  input  logic [DIM*ELEM_W-1:0]   q_vec,
  input  logic [NODE_W-1:0]       node_count,
  output logic                    mem_rd_en,
  output logic [NODE_W-1:0]       mem_rd_addr,
  input  logic [DIM*ELEM_W-1:0]   mem_rd_vec,
  input  logic [CLASS_W-1:0]      mem_rd_class,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [NODE_W-1:0]       res_node,
  output logic [CLASS_W-1:0]      res_class,
  output logic [DIST_W-1:0]       res_dist,
  output logic                    res_empty
);

  localparam int unsigned E_W  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned SQ_W = 2*ELEM_W + 2;

  typedef enum logic [2:0] {IDLE, RD, ACC, CMP, DONE} state_t;
  state_t state, state_nxt;

  logic [DIM*ELEM_W-1:0] q_reg, w_reg, w_src;
  logic [CLASS_W-1:0]    cls_reg, best_class;
  logic [NODE_W-1:0]     cnt, k, best_node, cnt_in;
  logic [E_W-1:0]        e;
  logic [DIST_W-1:0]     partial, min_dist, acc_nxt;
  logic                  empty;

  logic signed [ELEM_W-1:0] q_el, w_el;
  logic signed [ELEM_W:0]   diff;
  logic signed [SQ_W-1:0]   diff_x, sq;
  logic                     last_el, last_node, accept, adv_k;

  assign cnt_in    = (node_count > NODE_W'(NODE_MAX)) ? NODE_W'(NODE_MAX) : node_count;
  assign last_el   = (e == E_W'(DIM-1));
  assign last_node = (k == cnt - NODE_W'(1));
  assign accept    = q_valid && (state == IDLE);

  // Element 0 is taken straight from the read port on the first ACC cycle.
  always_comb begin
    q_el  = '0;
    w_el  = '0;
    w_src = (e == '0) ? mem_rd_vec : w_reg;
    for (int unsigned i = 0; i < DIM; i++) begin
      if (e == E_W'(i)) begin
        q_el = q_reg[i*ELEM_W +: ELEM_W];
        w_el = w_src[i*ELEM_W +: ELEM_W];
      end
    end
    diff    = $signed({q_el[ELEM_W-1], q_el}) - $signed({w_el[ELEM_W-1], w_el});
    diff_x  = {{(ELEM_W+1){diff[ELEM_W]}}, diff};
    sq      = diff_x * diff_x;
    acc_nxt = ((e == '0) ? '0 : partial) + {{(DIST_W-SQ_W){1'b0}}, sq};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    q_ready     = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    res_valid   = 1'b0;
    adv_k       = 1'b0;
    case (state)
      IDLE: begin
        q_ready = 1'b1;
        if (q_valid) state_nxt = (cnt_in == '0) ? DONE : RD;
      end
      RD: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = k;
        state_nxt   = ACC;
      end
      ACC: begin
        if (last_el) state_nxt = CMP;
`ifdef GAM_RECALL_EARLY_EXIT_EN
        // A node already at or above the min can never win the strict compare.
        if (acc_nxt >= min_dist) begin
          state_nxt = last_node ? DONE : RD;
          adv_k     = !last_node;
        end
`endif
      end
      CMP: begin
        state_nxt = last_node ? DONE : RD;
        adv_k     = !last_node;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg      <= '0;
      w_reg      <= '0;
      cls_reg    <= '0;
      cnt        <= '0;
      k          <= '0;
      e          <= '0;
      partial    <= '0;
      min_dist   <= '0;
      best_node  <= '0;
      best_class <= '0;
      empty      <= 1'b0;
    end else begin
      if (accept) begin
        q_reg      <= q_vec;
        cnt        <= cnt_in;
        k          <= '0;
        min_dist   <= '1;
        best_node  <= '0;
        best_class <= '0;
        empty      <= (cnt_in == '0);
      end
      if (state == RD) e <= '0;
      if (state == ACC) begin
        e       <= e + 1'b1;
        partial <= acc_nxt;
        if (e == '0) begin
          w_reg   <= mem_rd_vec;
          cls_reg <= mem_rd_class;
        end
      end
      if (state == CMP && partial < min_dist) begin
        min_dist   <= partial;
        best_node  <= k;
        best_class <= cls_reg;
      end
      if (adv_k) k <= k + 1'b1;
    end
  end

  assign res_node  = best_node;
  assign res_class = best_class;
  assign res_dist  = min_dist;
  assign res_empty = empty;

endmodule

// File: tb/tb_gam_recall_engine.sv
// Directed bench for gam_recall_engine with a registered node-memory model.
module tb_gam_recall_engine;

  localparam int unsigned DIM = 4, ELEM_W = 16, NODE_MAX = 64, NODE_W = 7, CLASS_W = 8, DIST_W = 40;

  logic                  clk, rst_n, q_valid, q_ready, mem_rd_en, res_valid, res_ready, res_empty;
  logic [DIM*ELEM_W-1:0] q_vec, mem_rd_vec;
  logic [NODE_W-1:0]     node_count, mem_rd_addr, res_node;
  logic [CLASS_W-1:0]    mem_rd_class, res_class;
  logic [DIST_W-1:0]     res_dist;

  logic [DIM*ELEM_W-1:0] mem_vec [128];
  logic [CLASS_W-1:0]    mem_cls [128];

  int n_tests = 0, n_fail = 0, rd_pulses = 0;

  gam_recall_engine #(
    .DIM(DIM), .ELEM_W(ELEM_W), .NODE_MAX(NODE_MAX),
    .NODE_W(NODE_W), .CLASS_W(CLASS_W), .DIST_W(DIST_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .q_valid(q_valid), .q_ready(q_ready), .q_vec(q_vec),
    .node_count(node_count), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_vec(mem_rd_vec), .mem_rd_class(mem_rd_class), .res_valid(res_valid),
    .res_ready(res_ready), .res_node(res_node), .res_class(res_class),
    .res_dist(res_dist), .res_empty(res_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_vec   <= mem_vec[mem_rd_addr];
      mem_rd_class <= mem_cls[mem_rd_addr];
      rd_pulses    <= rd_pulses + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Present a query from IDLE; lat counts cycles from accept edge to res_valid.
  task automatic run_query(input logic [63:0] q, input logic [6:0] n, output int lat);
    q_vec = q; node_count = n; q_valid = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 600) begin
      @(posedge clk); #1;
      lat++;
    end
    check("timeout", {63'd0, res_valid}, 64'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("drop_valid", {63'd0, res_valid}, 64'd0);
    check("idle_ready", {63'd0, q_ready}, 64'd1);
  endtask

  int lat, p0;
  logic [NODE_W-1:0]  hold_node;
  logic [CLASS_W-1:0] hold_class;
  logic [DIST_W-1:0]  hold_dist;

  initial begin
    rst_n = 1'b0; q_valid = 1'b0; res_ready = 1'b0; q_vec = '0; node_count = '0;
    for (int i = 0; i < 128; i++) begin
      mem_vec[i] = '0;
      mem_cls[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check("rst_dist", 64'(res_dist), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_q_ready", {63'd0, q_ready}, 64'd1);

    mem_vec[0] = pk(10, 10, 10, 10); mem_cls[0] = 8'd5;
    mem_vec[1] = pk(1, 2, 3, 4);     mem_cls[1] = 8'd7;
    mem_vec[2] = pk(0, 0, 0, 0);     mem_cls[2] = 8'd2;

    // Abort a scan in the middle of ACC
    q_vec = pk(1, 2, 3, 5); node_count = 7'd3; q_valid = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, res_valid}, 64'd0);
    check("midrst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    check("midrst_q_ready", {63'd0, q_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("midrst_no_result", {63'd0, res_valid}, 64'd0);

    // Basic recall with backpressure
    p0 = rd_pulses;
    run_query(pk(1, 2, 3, 5), 7'd3, lat);
    check("basic_node", 64'(res_node), 64'd1);
    check("basic_class", 64'(res_class), 64'd7);
    check("basic_dist", 64'(res_dist), 64'd1);
    check("basic_empty", {63'd0, res_empty}, 64'd0);
`ifdef GAM_RECALL_EARLY_EXIT_EN
    check("basic_lat_short", {63'd0, lat < 19}, 64'd1);
`else
    check("basic_lat", 64'(lat), 64'd19);
    check("basic_rd_pulses", 64'(rd_pulses - p0), 64'd3);
`endif
    hold_node = res_node; hold_class = res_class; hold_dist = res_dist;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {63'd0, res_valid}, 64'd1);
      check("bp_q_ready", {63'd0, q_ready}, 64'd0);
      check("bp_node", 64'(res_node), 64'(hold_node));
      check("bp_class", 64'(res_class), 64'(hold_class));
      check("bp_dist", 64'(res_dist), 64'(hold_dist));
    end
    consume();

    // Tie: lower index wins
    mem_vec[0] = pk(4, 4, 4, 4); mem_cls[0] = 8'd3;
    mem_vec[1] = pk(4, 4, 4, 4); mem_cls[1] = 8'd9;
    run_query(pk(4, 4, 4, 4), 7'd2, lat);
    check("tie_node", 64'(res_node), 64'd0);
    check("tie_class", 64'(res_class), 64'd3);
    check("tie_dist", 64'(res_dist), 64'd0);
    consume();

    // Empty store
    p0 = rd_pulses;
    run_query(pk(1, 1, 1, 1), 7'd0, lat);
    check("empty_lat", 64'(lat), 64'd1);
    check("empty_flag", {63'd0, res_empty}, 64'd1);
    check("empty_dist", 64'(res_dist), 64'hFF_FFFF_FFFF);
    check("empty_no_rd", 64'(rd_pulses - p0), 64'd0);
    consume();

    // Extreme operands: |diff| = 65535 per element
    mem_vec[0] = {4{16'h7FFF}}; mem_cls[0] = 8'd11;
    run_query({4{16'h8000}}, 7'd1, lat);
    check("ext_dist", 64'(res_dist), 64'd17179344900);
    check("ext_node", 64'(res_node), 64'd0);
    check("ext_class", 64'(res_class), 64'd11);
`ifndef GAM_RECALL_EARLY_EXIT_EN
    check("ext_lat", 64'(lat), 64'd7);
`endif
    consume();

    // node_count above NODE_MAX is clamped: node 70 (exact match) must not be scanned
    for (int i = 0; i < 128; i++) begin
      mem_vec[i] = pk(100, 100, 100, 100);
      mem_cls[i] = 8'(i);
    end
    mem_vec[63] = pk(0, 0, 0, 1); mem_cls[63] = 8'hAA;
    mem_vec[70] = pk(0, 0, 0, 0); mem_cls[70] = 8'h55;
    run_query(pk(0, 0, 0, 0), 7'd100, lat);
    check("clamp_node", 64'(res_node), 64'd63);
    check("clamp_class", 64'(res_class), 64'hAA);
    check("clamp_dist", 64'(res_dist), 64'd1);
`ifndef GAM_RECALL_EARLY_EXIT_EN
    check("clamp_lat", 64'(lat), 64'd385);
`endif
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
